// File: rtl/scoreboard_regfile.sv
// Register file with a pending-write scoreboard: two write ports, two combinational
// read ports with optional write forwarding, and single-slot reservations per cycle.
module scoreboard_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_reg [NREG];
  logic [NREG-1:0]   pending_reg;
  logic [NREG-1:0]   pending_next;
  logic [NREG-1:0]   wr_hit0;
  logic [NREG-1:0]   wr_hit1;
  logic [NREG-1:0]   rsv_hit;
  logic [ADDR_W:0]   pend_cnt_reg;
  logic [ADDR_W:0]   pend_cnt_next;
  logic              wr_act0;
  logic              wr_act1;
  logic              rsv_ok_int;

  logic [ADDR_W-1:0] rd_addr_arr [2];
  logic [DATA_W-1:0] rd_data_arr [2];
  logic              rd_busy_arr [2];

  // Gating with rst keeps forwarding and reservations silent while in reset.
  assign wr_act0 = wr_en0 && !rst && !(ZERO_REG != 0 && wr_addr0 == '0);
  assign wr_act1 = wr_en1 && !rst && !(ZERO_REG != 0 && wr_addr1 == '0);

  assign rsv_ok_int = rsv_en && !rst && !(ZERO_REG != 0 && rsv_addr == '0) &&
                      (!pending_reg[rsv_addr] ||
                       (wr_act0 && wr_addr0 == rsv_addr) ||
                       (wr_act1 && wr_addr1 == rsv_addr));

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    assign wr_hit0[gi] = wr_act0 && (wr_addr0 == ADDR_W'(gi));
    assign wr_hit1[gi] = wr_act1 && (wr_addr1 == ADDR_W'(gi));
    assign rsv_hit[gi] = rsv_ok_int && (rsv_addr == ADDR_W'(gi));
    // A reservation beats a same-cycle write clear, so the slot stays pending.
    assign pending_next[gi] = rsv_hit[gi] | (pending_reg[gi] & ~(wr_hit0[gi] | wr_hit1[gi]));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        regs_reg[gi] <= DATA_W'(gi);
      end else if (wr_hit1[gi]) begin
        regs_reg[gi] <= wr_data1;
      end else if (wr_hit0[gi]) begin
        regs_reg[gi] <= wr_data0;
      end
    end
  end

  always_comb begin
    pend_cnt_next = '0;
    for (int i = 0; i < NREG; i++) begin
      pend_cnt_next = pend_cnt_next + {{ADDR_W{1'b0}}, pending_next[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg  <= '0;
      pend_cnt_reg <= '0;
    end else begin
      pending_reg  <= pending_next;
      pend_cnt_reg <= pend_cnt_next;
    end
  end

  assign rd_addr_arr[0] = rd_addr_a;
  assign rd_addr_arr[1] = rd_addr_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    always_comb begin
      rd_data_arr[gi] = regs_reg[rd_addr_arr[gi]];
      rd_busy_arr[gi] = pending_reg[rd_addr_arr[gi]];
      if (BYPASS != 0) begin
        if (wr_act1 && wr_addr1 == rd_addr_arr[gi]) begin
          rd_data_arr[gi] = wr_data1;
          rd_busy_arr[gi] = 1'b0;
        end else if (wr_act0 && wr_addr0 == rd_addr_arr[gi]) begin
          rd_data_arr[gi] = wr_data0;
          rd_busy_arr[gi] = 1'b0;
        end
      end
      if (ZERO_REG != 0 && rd_addr_arr[gi] == '0) begin
        rd_data_arr[gi] = '0;
        rd_busy_arr[gi] = 1'b0;
      end
    end
  end

  assign rd_data_a = rd_data_arr[0];
  assign rd_data_b = rd_data_arr[1];
  assign rd_busy_a = rd_busy_arr[0];
  assign rd_busy_b = rd_busy_arr[1];
  assign rsv_ok    = rsv_ok_int;
  assign pend_cnt  = pend_cnt_reg;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Bench for scoreboard_regfile: directed scenarios plus random traffic checked
// against an array-based model of registers and pending flags.
module tb_scoreboard_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr0, wr_addr1, rsv_addr;
  logic [DW-1:0] rd_data_a, rd_data_b, wr_data0, wr_data1;
  logic          rd_busy_a, rd_busy_b, wr_en0, wr_en1, rsv_en, rsv_ok;
  logic [AW:0]   pend_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [N];
  logic        m_pend [N];

  logic [31:0] obs_rda, obs_rdb, obs_cnt_pre, obs_cnt_post;
  logic        obs_busy_a, obs_busy_b, obs_rsv;

  scoreboard_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .wr_en0(wr_en0), .wr_en1(wr_en1),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic fwd0(input logic [AW-1:0] a);
    return wr_en0 && wr_addr0 != 0 && wr_addr0 == a;
  endfunction

  function automatic logic fwd1(input logic [AW-1:0] a);
    return wr_en1 && wr_addr1 != 0 && wr_addr1 == a;
  endfunction

  function automatic logic [31:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return 32'd0;
    if (fwd1(a)) return wr_data1;
    if (fwd0(a)) return wr_data0;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0 || fwd0(a) || fwd1(a)) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic logic exp_rsv();
    return rsv_en && rsv_addr != 0 &&
           (!m_pend[rsv_addr] || fwd0(rsv_addr) || fwd1(rsv_addr));
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_regs[i] = 32'(i);
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 2) == 0) return AW'($urandom_range(0, N - 1));
    return AW'($urandom_range(0, 5));
  endfunction

  // One clock cycle: drive, check combinational outputs, clock, update model, check count.
  task automatic cycle(input logic e0, input logic [AW-1:0] a0, input logic [31:0] d0,
                       input logic e1, input logic [AW-1:0] a1, input logic [31:0] d1,
                       input logic re, input logic [AW-1:0] ra,
                       input logic [AW-1:0] rda, input logic [AW-1:0] rdb);
    logic ok;
    wr_en0 = e0; wr_addr0 = a0; wr_data0 = d0;
    wr_en1 = e1; wr_addr1 = a1; wr_data1 = d1;
    rsv_en = re; rsv_addr = ra;
    rd_addr_a = rda; rd_addr_b = rdb;
    #3;
    obs_rda = rd_data_a; obs_rdb = rd_data_b;
    obs_busy_a = rd_busy_a; obs_busy_b = rd_busy_b;
    obs_rsv = rsv_ok; obs_cnt_pre = 32'(pend_cnt);
    check("rd_data_a", obs_rda, exp_data(rda));
    check("rd_data_b", obs_rdb, exp_data(rdb));
    check("rd_busy_a", 32'(obs_busy_a), 32'(exp_busy(rda)));
    check("rd_busy_b", 32'(obs_busy_b), 32'(exp_busy(rdb)));
    ok = exp_rsv();
    check("rsv_ok", 32'(obs_rsv), 32'(ok));
    check("pend_cnt_hold", obs_cnt_pre, 32'(m_count()));
    @(posedge clk);
    #1;
    if (e0 && a0 != 0) begin m_regs[a0] = d0; m_pend[a0] = 1'b0; end
    if (e1 && a1 != 0) begin m_regs[a1] = d1; m_pend[a1] = 1'b0; end
    if (ok) m_pend[ra] = 1'b1;
    obs_cnt_post = 32'(pend_cnt);
    check("pend_cnt", obs_cnt_post, 32'(m_count()));
  endtask

  initial begin
    rst = 1'b1;
    wr_en0 = 0; wr_en1 = 0; wr_addr0 = 0; wr_addr1 = 0; wr_data0 = 0; wr_data1 = 0;
    rsv_en = 0; rsv_addr = 0; rd_addr_a = 7; rd_addr_b = 31;
    model_reset();
    repeat (2) @(posedge clk);
    // Outputs follow reset state even with live requests on the inputs.
    wr_en0 = 1; wr_addr0 = 7; wr_data0 = 32'hFF; rsv_en = 1; rsv_addr = 3;
    #2;
    check("rst_rd_data_a", rd_data_a, 32'd7);
    check("rst_rd_data_b", rd_data_b, 32'd31);
    check("rst_pend_cnt", 32'(pend_cnt), 32'd0);
    check("rst_rsv_ok", 32'(rsv_ok), 32'd0);
    wr_en0 = 0; rsv_en = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    cycle(0, 0, 0, 0, 0, 0, 0, 0, 7, 31);
    check("r7_after_reset", obs_rda, 32'd7);
    check("r31_after_reset", obs_rdb, 32'd31);
    check("busy7_after_reset", 32'(obs_busy_a), 32'd0);
    check("cnt_after_reset", obs_cnt_pre, 32'd0);

    cycle(0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
    check("r5_busy", 32'(obs_busy_a), 32'd1);
    check("r5_cnt", obs_cnt_pre, 32'd1);
    check("r5_rsv_again", 32'(obs_rsv), 32'd0);

    cycle(1, 5, 32'hDEAD, 0, 0, 0, 0, 0, 5, 5);
    check("r5_bypass", obs_rda, 32'hDEAD);
    check("r5_bypass_busy", 32'(obs_busy_a), 32'd0);
    check("r5_cnt_clear", obs_cnt_post, 32'd0);

    cycle(1, 9, 32'h1, 1, 9, 32'h2, 0, 0, 1, 2);
    cycle(1, 0, 32'h55, 0, 0, 0, 0, 0, 9, 0);
    check("r9_port1_wins", obs_rda, 32'h2);
    check("r0_write_ignored", obs_rdb, 32'h0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 9);
    check("r0_rsv", 32'(obs_rsv), 32'd0);
    check("r0_read", obs_rda, 32'd0);

    cycle(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
    cycle(1, 3, 32'hABC, 0, 0, 0, 1, 3, 3, 0);
    check("r3_rsv_with_write", 32'(obs_rsv), 32'd1);
    check("r3_cnt_same", obs_cnt_post, obs_cnt_pre);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    check("r3_data", obs_rda, 32'hABC);
    check("r3_still_busy", 32'(obs_busy_a), 32'd1);

    for (int k = 0; k < 300; k++) begin
      cycle(1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
            1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
            1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), rnd_addr());
    end

    for (int r = 1; r < N; r++) begin
      cycle(0, 0, 0, 0, 0, 0, 1, AW'(r), AW'(r), 0);
    end
    check("all_reserved", obs_cnt_post, 32'd31);

    // Asynchronous reset between edges, with a write to r4 in flight.
    rd_addr_a = 4; rd_addr_b = 6; rsv_en = 0;
    wr_en0 = 1; wr_addr0 = 4; wr_data0 = 32'h99;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_cnt", 32'(pend_cnt), 32'd0);
    check("async_rst_r4", rd_data_a, 32'd4);
    check("async_rst_busy", 32'(rd_busy_b), 32'd0);
    model_reset();
    @(negedge clk);
    wr_en0 = 0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(0, 0, 0, 0, 0, 0, 1, 4, 4, 6);
    check("r4_after_async", obs_rda, 32'd4);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 4, 6);
    check("r4_busy_after_async", 32'(obs_busy_a), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 Parameter: DATA_W, 32, register width in bits.
REQ-002 Parameter: ADDR_W, 5, address width; register count NREG = 2**ADDR_W.
REQ-003 Parameter: ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never reservable.
REQ-004 Parameter: BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports.
REQ-005 Port: clk  in  1  clock; all state updates on rising edge.
REQ-006 Port: rst  in  1  reset, asynchronous, active-high.
REQ-007 Port: rd_addr_a, rd_addr_b  in  ADDR_W  read port A and read port B addresses.
REQ-008 Port: rd_data_a, rd_data_b  out  DATA_W  read data, combinational.
REQ-009 Port: rd_busy_a, rd_busy_b  out  1  addressed register has a pending write.
REQ-010 Port: wr_en0, wr_en1  in  1  write enables, port 0 and port 1.
REQ-011 Port: wr_addr0, wr_addr1  in  ADDR_W  write addresses.
REQ-012 Port: wr_data0, wr_data1  in  DATA_W  write data.
REQ-013 Port: rsv_en  in  1  request to reserve (mark pending) register rsv_addr.
REQ-014 Port: rsv_addr  in  ADDR_W  register to reserve.
REQ-015 Port: rsv_ok  out  1  reservation accepted this cycle, combinational.
REQ-016 Port: pend_cnt  out  ADDR_W+1  number of pending registers, registered.

Function
REQ-017 The register array and a pending bit per register are state; both SHALL update only on the clk rising edge or on rst.
REQ-018 A write on port p SHALL occur when wr_enp=1, and wr_addrp!=0 when ZERO_REG=1.
REQ-019 Both ports writing the same address in one cycle: port 1 data SHALL be stored.
REQ-020 Read data SHALL be the array value; with BYPASS=1, a same-cycle enabled write to the read address SHALL be forwarded (port 1 over port 0).
REQ-021 With ZERO_REG=1, a read of address 0 SHALL return 0 regardless of bypass.
REQ-022 rsv_ok SHALL be 1 when rsv_en=1 and the target is not address 0 under ZERO_REG, and either pending[rsv_addr]=0 or a same-cycle write targets rsv_addr.
REQ-023 At the edge, pending[a] SHALL be set if rsv_ok and rsv_addr=a; otherwise pending[a] SHALL be cleared if any write targets a; otherwise it SHALL hold.
REQ-024 Same-cycle write to, and reservation of, the same address: data SHALL be stored and pending SHALL remain 1.
REQ-025 A write to a non-pending register SHALL be legal and SHALL leave pending at 0.
REQ-026 rd_busy_x SHALL equal pending[rd_addr_x], forced 0 when BYPASS=1 and a same-cycle write targets rd_addr_x, and forced 0 for address 0 under ZERO_REG.
REQ-027 pend_cnt SHALL equal the population count of the pending bits after each edge, with latency 1 cycle from the causing event and range 0..NREG.
REQ-028 Each edge SHALL accept at most one reservation and at most two writes.

Reset
REQ-029 While rst=1, register i SHALL equal i truncated to DATA_W, all pending bits SHALL be 0, and pend_cnt SHALL be 0.
REQ-030 rst asserted mid-operation SHALL discard in-flight writes and reservations immediately, without waiting for clk.
REQ-031 Combinational outputs SHALL follow the reset state while rst=1.

Verification
REQ-032 Reset, then read addresses 7 and 31 -> rd_data_a=7, rd_data_b=31, both busy=0, pend_cnt=0.
REQ-033 Reserve r5, next cycle read r5 -> rd_busy_a=1 and pend_cnt=1; a second reserve of r5 -> rsv_ok=0.
REQ-034 Write r5=0xDEAD on port 0 while reading r5 (BYPASS=1) -> rd_data=0xDEAD and busy=0 in the same cycle; next cycle pend_cnt=0.
REQ-035 Both ports write r9 (0x1, 0x2) -> r9 reads 0x2; a port 0 write to r0 -> r0 reads 0, and a reserve of r0 -> rsv_ok=0.
REQ-036 Pending r3, then write r3 and reserve r3 in the same cycle -> rsv_ok=1, r3 updated, pending stays 1, pend_cnt unchanged.
REQ-037 Reserve all 31 non-zero registers -> pend_cnt=31; assert rst asynchronously between edges -> pend_cnt=0 and r4 reads 4 before the next edge.
